// File: rtl/fifo_uart_tx_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_reader
// Description : Read-side consumer of a first-word-fall-through dual-clock
//               FIFO. Pops one word at a time and sends it as a UART frame:
//               start bit, data LSB first, optional parity, one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      R_CLK,
    input  logic                      R_RST,
    input  logic                      R_EMPTY,
    input  logic [DATA_WIDTH-1:0]     R_DATA,
    input  logic                      TX_EN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      RINC,
    output logic                      TX_OUT,
    output logic                      BUSY,
    output logic                      FRAME_DONE
);

    localparam int c_bcnt_w = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_start  = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_parity = 3'd4;
    localparam logic [2:0] c_st_stop   = 3'd5;

    localparam logic [c_bcnt_w-1:0]       c_last_bit = c_bcnt_w'(DATA_WIDTH - 1);
    localparam logic [c_bcnt_w-1:0]       c_bcnt_one = c_bcnt_w'(1);
    localparam logic [PRESCALE_WIDTH-1:0] c_pre_one  = PRESCALE_WIDTH'(1);

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_parity;
    logic                      r_par_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
    logic [c_bcnt_w-1:0]       r_bit_cnt;
    logic [PRESCALE_WIDTH-1:0] w_presc_last;
    logic                      w_bit_end;
    logic                      w_start_ok;

    // A prescale of zero is treated as one clock per bit.
    assign w_presc_last = (r_prescale == '0) ? '0 : (r_prescale - c_pre_one);
    assign w_bit_end    = (r_presc_cnt == w_presc_last);
    assign w_start_ok   = TX_EN && !R_EMPTY;

    // State register.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; R_EMPTY only matters in IDLE and at the end of STOP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (w_start_ok) w_next_state = c_st_load;
            c_st_load:   w_next_state = c_st_start;
            c_st_start:  if (w_bit_end) w_next_state = c_st_data;
            c_st_data: begin
                if (w_bit_end && (r_bit_cnt == c_last_bit)) begin
                    w_next_state = r_par_en ? c_st_parity : c_st_stop;
                end
            end
            c_st_parity: if (w_bit_end) w_next_state = c_st_stop;
            c_st_stop: begin
                if (w_bit_end) w_next_state = w_start_ok ? c_st_load : c_st_idle;
            end
            default:     w_next_state = c_st_idle;
        endcase
    end

    // Frame datapath: capture word and settings at LOAD, then time and shift bits.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_par_en    <= 1'b0;
            r_prescale  <= '0;
            r_presc_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_load: begin
                    r_shift     <= R_DATA;
                    r_parity    <= (^R_DATA) ^ PAR_TYP;
                    r_par_en    <= PAR_EN;
                    r_prescale  <= PRESCALE;
                    r_presc_cnt <= '0;
                    r_bit_cnt   <= '0;
                end
                c_st_start, c_st_data, c_st_parity, c_st_stop: begin
                    r_presc_cnt <= w_bit_end ? '0 : (r_presc_cnt + c_pre_one);
                    if ((r_state == c_st_data) && w_bit_end) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= (r_bit_cnt == c_last_bit) ? '0 : (r_bit_cnt + c_bcnt_one);
                    end
                end
                default: begin
                    r_presc_cnt <= '0;
                    r_bit_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        RINC       = 1'b0;
        TX_OUT     = 1'b1;
        BUSY       = (r_state != c_st_idle);
        FRAME_DONE = 1'b0;
        case (r_state)
            c_st_load:   RINC = 1'b1;
            c_st_start:  TX_OUT = 1'b0;
            c_st_data:   TX_OUT = r_shift[0];
            c_st_parity: TX_OUT = r_parity;
            c_st_stop:   FRAME_DONE = w_bit_end;
            default:     TX_OUT = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx_reader
// Description : Self-checking bench for fifo_uart_tx_reader. A queue models
//               the FWFT FIFO; expected line activity is built per frame as
//               a list of per-clock expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx_reader;

    localparam int c_dw = 8;
    localparam int c_pw = 8;

    localparam int K_IDLE = 0, K_LOAD = 1, K_START = 2, K_DATA = 3, K_PAR = 4, K_STOP = 5;

    typedef struct {
        logic tx;
        logic busy;
        logic rinc;
        logic done;
        int   kind;
        int   bitn;
    } ent_t;

    logic            R_CLK = 1'b0;
    logic            R_RST;
    logic            R_EMPTY;
    logic [c_dw-1:0] R_DATA;
    logic            TX_EN;
    logic            PAR_EN;
    logic            PAR_TYP;
    logic [c_pw-1:0] PRESCALE;
    logic            RINC;
    logic            TX_OUT;
    logic            BUSY;
    logic            FRAME_DONE;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        rinc_cnt = 0;
    logic      pending_pop = 1'b0;
    logic [7:0] fifo_q[$];
    ent_t      exp_q[$];
    ent_t      cur;

    fifo_uart_tx_reader #(.DATA_WIDTH(c_dw), .PRESCALE_WIDTH(c_pw)) u_dut (
        .R_CLK(R_CLK), .R_RST(R_RST), .R_EMPTY(R_EMPTY), .R_DATA(R_DATA),
        .TX_EN(TX_EN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
        .RINC(RINC), .TX_OUT(TX_OUT), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 R_CLK = ~R_CLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic ent_t mk(input logic tx, input logic busy, input logic rinc,
                                input logic done, input int kind, input int bitn);
        ent_t e;
        e.tx = tx; e.busy = busy; e.rinc = rinc; e.done = done; e.kind = kind; e.bitn = bitn;
        return e;
    endfunction

    task automatic refresh_fifo();
        R_EMPTY = (fifo_q.size() == 0);
        R_DATA  = R_EMPTY ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        refresh_fifo();
    endtask

    // One UART bit: p clocks at level b.
    task automatic add_bit(input int kind, input logic b, input int idx, input int p, input bit last);
        for (int j = 0; j < p; j++)
            exp_q.push_back(mk(b, 1'b1, 1'b0, (last && j == p - 1), kind, idx));
    endtask

    task automatic gen_frame(input logic [7:0] w, input logic [7:0] pr, input logic pe, input logic pt);
        int p;
        p = (pr == 0) ? 1 : int'(pr);
        add_bit(K_START, 1'b0, 0, p, 0);
        for (int i = 0; i < c_dw; i++) add_bit(K_DATA, w[i], i, p, 0);
        if (pe) add_bit(K_PAR, (^w) ^ pt, 0, p, 0);
        add_bit(K_STOP, 1'b1, 0, p, 1);
    endtask

    // Advance the reference by one clock using the inputs present before the edge.
    task automatic model_step();
        if (R_RST) begin
            exp_q.delete();
        end else begin
            if (cur.kind == K_LOAD) gen_frame(R_DATA, PRESCALE, PAR_EN, PAR_TYP);
            if (exp_q.size() == 0 && TX_EN && !R_EMPTY)
                exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, K_LOAD, 0));
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge R_CLK);
        #1;
        if (pending_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : mk(1'b1, 1'b0, 1'b0, 1'b0, K_IDLE, 0);
        chk_eq("tx_out", TX_OUT, cur.tx);
        chk_eq("busy", BUSY, cur.busy);
        chk_eq("rinc", RINC, cur.rinc);
        chk_eq("frame_done", FRAME_DONE, cur.done);
        pending_pop = RINC;
        if (RINC) rinc_cnt++;
        refresh_fifo();
    endtask

    task automatic drain(input int max_cyc);
        int  n;
        logic fin;
        n = 0;
        fin = 1'b0;
        while (!fin && n < max_cyc) begin
            cyc();
            n++;
            fin = (exp_q.size() == 0) && (cur.kind == K_IDLE) && (fifo_q.size() == 0 || !TX_EN);
        end
        chk_eq("drain_timeout", fin, 1'b1);
    endtask

    task automatic run_to_data3(input int max_cyc);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < max_cyc) begin
            cyc();
            n++;
            hit = (cur.kind == K_DATA) && (cur.bitn == 3);
        end
        chk_eq("wait_data3_timeout", hit, 1'b1);
    endtask

    initial begin
        int base;
        cur = mk(1'b1, 1'b0, 1'b0, 1'b0, K_IDLE, 0);
        R_RST = 1'b1; TX_EN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 8'd1;
        refresh_fifo();

        // Reset held with data available and TX enabled.
        push(8'h3C);
        for (int i = 0; i < 3; i++) cyc();
        R_RST = 1'b0;
        drain(200);

        // Single word, no parity, 4 clocks per bit.
        PRESCALE = 8'd4; PAR_EN = 1'b0;
        base = rinc_cnt;
        push(8'hA5);
        drain(200);
        chk_eq("rinc_pulses_single", rinc_cnt - base, 1);

        // Even and odd parity at 2 clocks per bit.
        PRESCALE = 8'd2; PAR_EN = 1'b1;
        for (int t = 0; t < 2; t++) begin
            PAR_TYP = t[0];
            push(8'hA5);
            drain(200);
        end

        // Three queued words, back to back at 1 clock per bit.
        PRESCALE = 8'd1; PAR_EN = 1'b0;
        base = rinc_cnt;
        push(8'h01); push(8'h80); push(8'hFF);
        drain(200);
        chk_eq("rinc_pulses_three", rinc_cnt - base, 3);

        // Empty FIFO with TX enabled, then data present with TX disabled.
        base = rinc_cnt;
        for (int i = 0; i < 100; i++) cyc();
        chk_eq("rinc_when_empty", rinc_cnt - base, 0);
        TX_EN = 1'b0;
        push(8'h5A);
        for (int i = 0; i < 20; i++) cyc();
        chk_eq("rinc_when_disabled", rinc_cnt - base, 0);
        TX_EN = 1'b1;
        drain(200);

        // TX_EN dropped mid-frame: the frame finishes, nothing else is popped.
        PRESCALE = 8'd2;
        base = rinc_cnt;
        push(8'hC3); push(8'h3C);
        run_to_data3(200);
        TX_EN = 1'b0;
        drain(200);
        chk_eq("rinc_after_txen_drop", rinc_cnt - base, 1);
        TX_EN = 1'b1;
        drain(200);

        // Reset during data bit 3, then a fresh frame; then prescale zero.
        PRESCALE = 8'd3;
        push(8'h96); push(8'h69);
        run_to_data3(200);
        R_RST = 1'b1;
        cyc();
        R_RST = 1'b0;
        drain(300);
        PRESCALE = 8'd0; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        push(8'h7E);
        drain(200);

        // Random traffic with settings changing at arbitrary times.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0 && fifo_q.size() < 4) push(8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                PRESCALE = 8'($urandom_range(0, 5));
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
            end
            if ($urandom_range(0, 39) == 0) TX_EN = ~TX_EN;
            if ($urandom_range(0, 499) == 0) R_RST = 1'b1;
            cyc();
            R_RST = 1'b0;
        end
        TX_EN = 1'b1;
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
